// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multi-cycle MIPS controller.
// States, opcodes, ALU codes and datapath mux select values.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_R_EXE,
    S_R_WB,
    S_I_EXE,
    S_I_WB,
    S_BRANCH,
    S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_OR  = 5'd2;
  localparam logic [4:0] ALU_SLT = 5'd3;
  localparam logic [4:0] ALU_LUI = 5'd4;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MDR = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [1:0] SB_REG    = 2'b00;
  localparam logic [1:0] SB_FOUR   = 2'b01;
  localparam logic [1:0] SB_EXT    = 2'b10;
  localparam logic [1:0] SB_EXT_SH = 2'b11;

  localparam logic [1:0] PS_ALU    = 2'b00;
  localparam logic [1:0] PS_ALUOUT = 2'b01;
  localparam logic [1:0] PS_JUMP   = 2'b10;

  function automatic logic is_legal(
    input logic [5:0] op,
    input logic [5:0] funct
  );
    if (op == OP_RTYPE)
      return (funct == FN_ADDU) ||
             (funct == FN_SUBU) ||
             (funct == FN_SLT);
    return (op == OP_J)     || (op == OP_JAL) ||
           (op == OP_BEQ)   || (op == OP_ADDIU) ||
           (op == OP_ORI)   || (op == OP_LUI) ||
           (op == OP_LW)    || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: controller <-> datapath bundle.
// master = controller, slave = datapath (IR fields, flags, memory ready).
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_wr;
  logic       ir_wr;
  logic       iord;
  logic       mem_rd;
  logic       mem_wr;
  logic [1:0] reg_dst;
  logic [1:0] data_to_reg;
  logic       reg_wr;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_op;
  logic [4:0] alu_ctr;
  logic [1:0] pc_src;
  logic       illegal;

  modport master (
    input  op, funct, zero, mem_ready,
    output pc_wr, ir_wr, iord, mem_rd, mem_wr,
    output reg_dst, data_to_reg, reg_wr,
    output alu_src_a, alu_src_b, ext_op, alu_ctr,
    output pc_src, illegal
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pc_wr, ir_wr, iord, mem_rd, mem_wr,
    input  reg_dst, data_to_reg, reg_wr,
    input  alu_src_a, alu_src_b, ext_op, alu_ctr,
    input  pc_src, illegal
  );
endinterface

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: ALU operation and extender mode for the current state.
// R-type ops come from funct, I-type from op; address phases add.
module mc_alu_dec
  import mc_pkg::*;
(
  input  state_t     st,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [4:0] alu_ctr,
  output logic       ext_op
);

  // per-state ALU op and extend mode
  always_comb begin
    alu_ctr = ALU_ADD;
    ext_op  = 1'b0;
    unique case (st)
      S_DECODE,
      S_MEM_ADR: ext_op = 1'b1;
      S_R_EXE: begin
        unique case (1'b1)
          (funct == FN_SUBU): alu_ctr = ALU_SUB;
          (funct == FN_SLT):  alu_ctr = ALU_SLT;
          default:            alu_ctr = ALU_ADD;
        endcase
      end
      S_I_EXE: begin
        unique case (1'b1)
          (op == OP_ORI): alu_ctr = ALU_OR;
          (op == OP_LUI): alu_ctr = ALU_LUI;
          default: begin
            alu_ctr = ALU_ADD;
            ext_op  = 1'b1;
          end
        endcase
      end
      S_BRANCH: alu_ctr = ALU_SUB;
      default: begin
        alu_ctr = ALU_ADD;
        ext_op  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM with memory ready stalls.
// Define MC_CTRL_PERF_EN to build the cycle/retire counters.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  mc_ctrl_if.master         bus,
  output logic [PERF_W-1:0] cyc_cnt,
  output logic [PERF_W-1:0] ins_cnt
);

  state_t state;
  state_t next;
  state_t cur;
  logic   legal;

  assign cur   = reset ? S_FETCH : state;
  assign legal = is_legal(bus.op, bus.funct);

  // next instruction phase
  always_comb begin
    next = state;
    unique case (state)
      S_FETCH:
        if (bus.mem_ready) next = S_DECODE;
      S_DECODE: begin
        next = S_FETCH;
        if (legal) begin
          unique case (1'b1)
            (bus.op == OP_LW),
            (bus.op == OP_SW):    next = S_MEM_ADR;
            (bus.op == OP_RTYPE): next = S_R_EXE;
            (bus.op == OP_ORI),
            (bus.op == OP_ADDIU),
            (bus.op == OP_LUI):   next = S_I_EXE;
            (bus.op == OP_BEQ):   next = S_BRANCH;
            default:              next = S_JUMP;
          endcase
        end
      end
      S_MEM_ADR:
        next = (bus.op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:
        if (bus.mem_ready) next = S_MEM_WB;
      S_MEM_WR:
        if (bus.mem_ready) next = S_FETCH;
      S_R_EXE: next = S_R_WB;
      S_I_EXE: next = S_I_WB;
      default: next = S_FETCH;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  // Moore outputs; reset forces the FETCH view with enables off
  always_comb begin
    bus.pc_wr       = 1'b0;
    bus.ir_wr       = 1'b0;
    bus.iord        = 1'b0;
    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.reg_wr      = 1'b0;
    bus.reg_dst     = RD_RT;
    bus.data_to_reg = WD_ALU;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = SB_FOUR;
    bus.pc_src      = PS_ALU;
    bus.illegal     = 1'b0;
    unique case (cur)
      S_FETCH: begin
        bus.mem_rd = 1'b1;
        bus.ir_wr  = bus.mem_ready;
        bus.pc_wr  = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_b = SB_EXT_SH;
        bus.illegal   = ~legal;
      end
      S_MEM_ADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SB_EXT;
      end
      S_MEM_RD: begin
        bus.mem_rd = 1'b1;
        bus.iord   = 1'b1;
      end
      S_MEM_WB: begin
        bus.reg_wr      = 1'b1;
        bus.data_to_reg = WD_MDR;
      end
      S_MEM_WR: begin
        bus.mem_wr = 1'b1;
        bus.iord   = 1'b1;
      end
      S_R_EXE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SB_REG;
      end
      S_R_WB: begin
        bus.reg_wr  = 1'b1;
        bus.reg_dst = RD_RD;
      end
      S_I_EXE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SB_EXT;
      end
      S_I_WB: bus.reg_wr = 1'b1;
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SB_REG;
        bus.pc_src    = PS_ALUOUT;
        bus.pc_wr     = bus.zero;
      end
      S_JUMP: begin
        bus.pc_wr  = 1'b1;
        bus.pc_src = PS_JUMP;
        if (bus.op == OP_JAL) begin
          bus.reg_wr      = 1'b1;
          bus.reg_dst     = RD_RA;
          bus.data_to_reg = WD_PC;
        end
      end
      default: bus.illegal = 1'b0;
    endcase
    if (reset) begin
      bus.mem_rd = 1'b0;
      bus.ir_wr  = 1'b0;
      bus.pc_wr  = 1'b0;
    end
  end

  mc_alu_dec u_alu_dec (
    .st      (cur),
    .op      (bus.op),
    .funct   (bus.funct),
    .alu_ctr (bus.alu_ctr),
    .ext_op  (bus.ext_op)
  );

`ifdef MC_CTRL_PERF_EN
  localparam logic [PERF_W-1:0] ONE = PERF_W'(1);
  logic              retire;
  logic [PERF_W-1:0] cyc_q;
  logic [PERF_W-1:0] ins_q;

  assign retire = (state == S_MEM_WB) ||
                  (state == S_R_WB) ||
                  (state == S_I_WB) ||
                  (state == S_BRANCH) ||
                  (state == S_JUMP) ||
                  ((state == S_MEM_WR) && bus.mem_ready);

  // cycle and retired-instruction counters
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_q + ONE;
      if (retire) ins_q <= ins_q + ONE;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ins_cnt = ins_q;
`else
  assign cyc_cnt = '0;
  assign ins_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized bench for mc_ctrl against a per-instruction
// phase model (expected signals and memory stalls built per instruction).
`timescale 1ns/1ps
module tb_mc_ctrl;
  localparam int PERF_W = 32;

  logic clk = 1'b0;
  logic reset;
  logic [PERF_W-1:0] cyc_cnt;
  logic [PERF_W-1:0] ins_cnt;
  int checks = 0;
  int errors = 0;
  int exp_cyc = 0;
  int exp_ins = 0;

  mc_ctrl_if bus();

  mc_ctrl #(.PERF_W(PERF_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .cyc_cnt (cyc_cnt),
    .ins_cnt (ins_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       illegal;
    logic [1:0] reg_dst;
    logic [1:0] dtr;
    logic [1:0] pc_src;
    logic       a;
    logic [1:0] b;
    logic [4:0] alu;
    logic       ext;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       rdy;
    logic       rdy_care;
    ctl_t       e;
    ctl_t       m;
    logic       retire;
    string      tag;
  } cyc_t;

  cyc_t exp_q[$];

  function automatic ctl_t obs();
    ctl_t o;
    o.pc_wr   = bus.pc_wr;
    o.ir_wr   = bus.ir_wr;
    o.iord    = bus.iord;
    o.mem_rd  = bus.mem_rd;
    o.mem_wr  = bus.mem_wr;
    o.reg_wr  = bus.reg_wr;
    o.illegal = bus.illegal;
    o.reg_dst = bus.reg_dst;
    o.dtr     = bus.data_to_reg;
    o.pc_src  = bus.pc_src;
    o.a       = bus.alu_src_a;
    o.b       = bus.alu_src_b;
    o.alu     = bus.alu_ctr;
    o.ext     = bus.ext_op;
    return o;
  endfunction

  function automatic ctl_t en_mask();
    ctl_t k = '0;
    k.pc_wr = 1; k.ir_wr = 1; k.mem_rd = 1;
    k.mem_wr = 1; k.reg_wr = 1; k.illegal = 1;
    return k;
  endfunction

  // 0 illegal, 1 load/store, 2 R-type, 3 I-type, 4 beq, 5 jump
  function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:   return (fn == 6'h21 || fn == 6'h23 || fn == 6'h2a) ? 2 : 0;
      6'h23, 6'h2b: return 1;
      6'h0d, 6'h09, 6'h0f: return 3;
      6'h04:   return 4;
      6'h02, 6'h03: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic void push(input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic rdy, input logic care,
                               input ctl_t e, input ctl_t m, input logic ret,
                               input string tag);
    cyc_t c;
    c.op = op; c.fn = fn; c.z = z; c.rdy = rdy; c.rdy_care = care;
    c.e = e; c.m = m; c.retire = ret; c.tag = tag;
    exp_q.push_back(c);
  endfunction

  // expected cycle-by-cycle behaviour of one instruction
  // f = fetch wait cycles, m = data memory wait cycles
  function automatic void plan(input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input int f, input int m);
    ctl_t e;
    ctl_t k;
    int   kd = kind(op, fn);
    for (int i = 0; i <= f; i++) begin
      e = '0; k = en_mask();
      e.mem_rd = 1; e.b = 2'b01;
      e.ir_wr = (i == f); e.pc_wr = (i == f);
      k.iord = 1; k.a = 1; k.b = '1; k.alu = '1; k.pc_src = '1;
      push(op, fn, z, i == f, 1, e, k, 0, "fetch");
    end
    e = '0; k = en_mask();
    e.b = 2'b11; e.ext = 1; e.illegal = (kd == 0);
    k.a = 1; k.b = '1; k.alu = '1; k.ext = 1;
    push(op, fn, z, 0, 0, e, k, 0, "decode");
    case (kd)
      1: begin
        e = '0; k = en_mask();
        e.a = 1; e.b = 2'b10; e.ext = 1;
        k.a = 1; k.b = '1; k.alu = '1; k.ext = 1;
        push(op, fn, z, 0, 0, e, k, 0, "mem_adr");
        for (int i = 0; i <= m; i++) begin
          e = '0; k = en_mask();
          e.iord = 1; k.iord = 1;
          if (op == 6'h23) e.mem_rd = 1;
          else e.mem_wr = 1;
          push(op, fn, z, i == m, 1, e, k, (op == 6'h2b) && (i == m), "mem_acc");
        end
        if (op == 6'h23) begin
          e = '0; k = en_mask();
          e.reg_wr = 1; e.reg_dst = 2'b00; e.dtr = 2'b01;
          k.reg_dst = '1; k.dtr = '1;
          push(op, fn, z, 0, 0, e, k, 1, "mem_wb");
        end
      end
      2: begin
        e = '0; k = en_mask();
        e.a = 1; e.b = 2'b00;
        e.alu = (fn == 6'h21) ? 5'd0 : (fn == 6'h23) ? 5'd1 : 5'd3;
        k.a = 1; k.b = '1; k.alu = '1;
        push(op, fn, z, 0, 0, e, k, 0, "r_exe");
        e = '0; k = en_mask();
        e.reg_wr = 1; e.reg_dst = 2'b01; e.dtr = 2'b00;
        k.reg_dst = '1; k.dtr = '1;
        push(op, fn, z, 0, 0, e, k, 1, "r_wb");
      end
      3: begin
        e = '0; k = en_mask();
        e.a = 1; e.b = 2'b10;
        k.a = 1; k.b = '1; k.alu = '1;
        if (op == 6'h0d) begin e.alu = 5'd2; e.ext = 0; k.ext = 1; end
        else if (op == 6'h09) begin e.alu = 5'd0; e.ext = 1; k.ext = 1; end
        else e.alu = 5'd4;
        push(op, fn, z, 0, 0, e, k, 0, "i_exe");
        e = '0; k = en_mask();
        e.reg_wr = 1; e.reg_dst = 2'b00; e.dtr = 2'b00;
        k.reg_dst = '1; k.dtr = '1;
        push(op, fn, z, 0, 0, e, k, 1, "i_wb");
      end
      4: begin
        e = '0; k = en_mask();
        e.a = 1; e.b = 2'b00; e.alu = 5'd1; e.pc_src = 2'b01; e.pc_wr = z;
        k.a = 1; k.b = '1; k.alu = '1; k.pc_src = '1;
        push(op, fn, z, 0, 0, e, k, 1, "branch");
      end
      5: begin
        e = '0; k = en_mask();
        e.pc_wr = 1; e.pc_src = 2'b10;
        k.pc_src = '1;
        if (op == 6'h03) begin
          e.reg_wr = 1; e.reg_dst = 2'b10; e.dtr = 2'b10;
          k.reg_dst = '1; k.dtr = '1;
        end
        push(op, fn, z, 0, 0, e, k, 1, "jump");
      end
      default: ;
    endcase
  endfunction

  function automatic logic [PERF_W-1:0] want_cnt(input int v);
`ifdef MC_CTRL_PERF_EN
    return PERF_W'(v);
`else
    return (v == v) ? '0 : '0;
`endif
  endfunction

  task automatic check_counters(input string tag);
    logic [PERF_W-1:0] wc;
    logic [PERF_W-1:0] wi;
    wc = want_cnt(exp_cyc);
    wi = want_cnt(exp_ins);
    checks++;
    if (cyc_cnt !== wc) begin
      errors++;
      $display("FAIL %s cyc_cnt: got %0d want %0d", tag, cyc_cnt, wc);
    end
    checks++;
    if (ins_cnt !== wi) begin
      errors++;
      $display("FAIL %s ins_cnt: got %0d want %0d", tag, ins_cnt, wi);
    end
  endtask

  // play queued cycles; stop after n cycles (abandoning the rest)
  task automatic run_plan(input int n);
    cyc_t c;
    ctl_t o;
    int   done = 0;
    while (exp_q.size() > 0 && done < n) begin
      c = exp_q.pop_front();
      @(negedge clk);
      bus.op = c.op;
      bus.funct = c.fn;
      bus.zero = c.z;
      bus.mem_ready = c.rdy_care ? c.rdy : 1'($urandom_range(0, 1));
      #1;
      if (done == 0) check_counters(c.tag);
      o = obs();
      checks++;
      if ((o & c.m) !== (c.e & c.m)) begin
        errors++;
        $display("FAIL %s op=%h fn=%h: got %h want %h mask %h",
                 c.tag, c.op, c.fn, o & c.m, c.e & c.m, c.m);
      end
      exp_cyc++;
      if (c.retire) exp_ins++;
      done++;
    end
    exp_q.delete();
  endtask

  // leave reset with the FETCH memory stalled for one cycle
  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if (!(bus.mem_rd === 1'b1 && bus.iord === 1'b0 && bus.ir_wr === 1'b0 &&
          bus.pc_wr === 1'b0 && bus.alu_src_b === 2'b01)) begin
      errors++;
      $display("FAIL post_reset_fetch: got rd=%b iord=%b ir=%b pc=%b b=%b want 1 0 0 0 01",
               bus.mem_rd, bus.iord, bus.ir_wr, bus.pc_wr, bus.alu_src_b);
    end
    check_counters("post_reset");
    exp_cyc = 1;
  endtask

  task automatic check_in_reset(input string tag);
    checks++;
    if ({bus.pc_wr, bus.ir_wr, bus.mem_rd, bus.mem_wr, bus.reg_wr, bus.illegal} !== 6'b0) begin
      errors++;
      $display("FAIL %s enables: got %b want 000000", tag,
               {bus.pc_wr, bus.ir_wr, bus.mem_rd, bus.mem_wr, bus.reg_wr, bus.illegal});
    end
    checks++;
    if ({bus.iord, bus.alu_src_a, bus.alu_src_b, bus.alu_ctr, bus.pc_src} !== 11'b0_0_01_00000_00) begin
      errors++;
      $display("FAIL %s selects: got %b want 00010000000", tag,
               {bus.iord, bus.alu_src_a, bus.alu_src_b, bus.alu_ctr, bus.pc_src});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.zero = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.op = 6'($urandom);
      bus.funct = 6'($urandom);
      #1;
      check_in_reset("reset");
    end
    exp_cyc = 0;
    exp_ins = 0;
    check_counters("reset");
    release_reset();
  endtask

  task automatic test_addu();
    plan(6'h00, 6'h21, 1'($urandom), 0, 0);
    run_plan(1000);
  endtask

  task automatic test_lw_slow();
    plan(6'h23, 6'h04, 1'($urandom), 0, 2);
    run_plan(1000);
  endtask

  task automatic test_beq();
    plan(6'h04, 6'h03, 1'b1, 0, 0);
    plan(6'h04, 6'h03, 1'b0, 1, 0);
    run_plan(1000);
  endtask

  task automatic test_jal();
    plan(6'h03, 6'h10, 1'b0, 0, 0);
    plan(6'h02, 6'h10, 1'b1, 2, 0);
    run_plan(1000);
  endtask

  task automatic test_illegal();
    plan(6'h3f, 6'h00, 1'b0, 0, 0);
    plan(6'h00, 6'h00, 1'b0, 1, 0);
    plan(6'h00, 6'h21, 1'b0, 0, 0);
    run_plan(1000);
  endtask

  task automatic test_reset_mid_sw();
    plan(6'h2b, 6'h08, 1'b0, 1, 3);
    run_plan(4);
    @(negedge clk);
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    check_in_reset("reset_mid_sw");
    exp_cyc = 0;
    exp_ins = 0;
    release_reset();
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [0:12];
    logic [5:0] fns [0:2];
    logic [5:0] op;
    logic [5:0] fn;
    ops = '{6'h00, 6'h00, 6'h00, 6'h0d, 6'h09, 6'h0f, 6'h23,
            6'h2b, 6'h04, 6'h02, 6'h03, 6'h3f, 6'h20};
    fns = '{6'h21, 6'h23, 6'h2a};
    for (int n = 0; n < 80; n++) begin
      op = ops[$urandom_range(0, 12)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 2)];
      plan(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    run_plan(100000);
  endtask

  initial begin
    bus.op = 6'h0;
    bus.funct = 6'h0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    test_reset();
    test_addu();
    test_lw_slow();
    test_beq();
    test_jal();
    test_illegal();
    test_reset_mid_sw();
    test_addu();
    test_back_to_back();
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    check_counters("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit that sequences the shared MIPS datapath (PC, one unified instruction/data memory, GPR, extender, single ALU) over several clocks per instruction, replacing the one-shot combinational `ctrl` decode. It holds the instruction phase in a Moore state machine and emits per-cycle enables and mux selects. It also stalls on a memory ready handshake, so the same controller works with multi-cycle memories.

## Interface
- `PERF_W`, default 32: width of the optional performance counters.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `op` input 6: `IR[31:26]` from the instruction register.
- `funct` input 6: `IR[5:0]`.
- `zero` input 1: ALU equality flag, valid during `BRANCH`.
- `mem_ready` input 1: memory has completed the current read or write this cycle.
- `pc_wr` output 1: PC load enable. Already includes the branch condition.
- `ir_wr` output 1: instruction register load enable.
- `iord` output 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_rd` output 1: memory read request.
- `mem_wr` output 1: memory write request.
- `reg_dst` output 2: write-register select. 00 = rt, 01 = rd, 10 = $31.
- `data_to_reg` output 2: write-data select. 00 = ALUOut, 01 = MDR, 10 = PC.
- `reg_wr` output 1: GPR write enable.
- `alu_src_a` output 1: ALU A select. 0 = PC, 1 = register A.
- `alu_src_b` output 2: ALU B select. 00 = register B, 01 = constant 4, 10 = ext, 11 = ext<<2.
- `ext_op` output 1: extender mode. 1 = sign extend, 0 = zero extend.
- `alu_ctr` output 5: ALU operation code.
- `pc_src` output 2: next-PC select. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal` output 1: one-cycle pulse in `DECODE` when the opcode or funct is unsupported.
- `cyc_cnt` output PERF_W: cycle counter.
- `ins_cnt` output PERF_W: retired-instruction counter.

## Operation
Supported instructions:
- R-type: `addu`, `subu`, `slt`.
- I-type: `ori`, `addiu`, `lui`.
- Memory: `lw`, `sw`.
- Control: `beq`, `j`, `jal`.

States, each with its asserted outputs (every unlisted enable is 0):
- **FETCH**: `mem_rd=1`, `iord=0`, `alu_src_a=0`, `alu_src_b=01`, ALU op ADD, `pc_src=00`. `ir_wr` and `pc_wr` equal `mem_ready`. Stays in FETCH until `mem_ready`, then goes to DECODE.
- **DECODE**: `alu_src_a=0`, `alu_src_b=11`, `ext_op=1`, ALU op ADD (precomputes the branch target).
  - `lw`/`sw` → MEM_ADR
  - R-type → R_EXE
  - `ori`/`addiu`/`lui` → I_EXE
  - `beq` → BRANCH
  - `j`/`jal` → JUMP
  - anything else → FETCH with `illegal=1`; the instruction is treated as a NOP.
- **MEM_ADR**: `alu_src_a=1`, `alu_src_b=10`, `ext_op=1`, ADD. Goes to MEM_RD for `lw`, MEM_WR for `sw`.
- **MEM_RD**: `mem_rd=1`, `iord=1`. Holds until `mem_ready`, then goes to MEM_WB.
- **MEM_WB**: `reg_wr=1`, `reg_dst=00`, `data_to_reg=01`. Goes to FETCH.
- **MEM_WR**: `mem_wr=1`, `iord=1`. Holds until `mem_ready`, then goes to FETCH.
- **R_EXE**: `alu_src_a=1`, `alu_src_b=00`, ALU op from `funct`. Goes to R_WB.
- **R_WB**: `reg_wr=1`, `reg_dst=01`, `data_to_reg=00`. Goes to FETCH.
- **I_EXE**: `alu_src_a=1`, `alu_src_b=10`.
  - `ori`: `ext_op=0`, OR.
  - `addiu`: `ext_op=1`, ADD.
  - `lui`: LUI.
  - Goes to I_WB.
- **I_WB**: `reg_wr=1`, `reg_dst=00`, `data_to_reg=00`. Goes to FETCH.
- **BRANCH**: `alu_src_a=1`, `alu_src_b=00`, SUB, `pc_src=01`, `pc_wr=zero`. Goes to FETCH.
- **JUMP**: `pc_wr=1`, `pc_src=10`. For `jal`, also `reg_wr=1`, `reg_dst=10`, `data_to_reg=10`; PC already holds PC+4 at this point. Goes to FETCH.

General rules:
- Outputs are combinational from the state register, plus `mem_ready`, `zero`, `op` and `funct` where stated above.
- There are no output registers.

## Timing
- Reset:
  - `reset` high at a rising edge sets state to FETCH.
  - While `reset` is high, every enable (`pc_wr`, `ir_wr`, `mem_rd`, `mem_wr`, `reg_wr`) is forced to 0 and `illegal` is 0.
  - All selects take their FETCH values.
  - Reset asserted mid-instruction abandons the instruction. No partial write is issued in the reset cycle.
- Latency with `mem_ready` tied to 1:
  - `lw`: 5 cycles.
  - `sw`, R-type, I-type: 4 cycles.
  - `beq`, `j`, `jal`: 3 cycles.
  - Each cycle that `mem_ready` is low in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- Memory handshake:
  - `mem_rd`/`mem_wr` stay high and `iord` stays stable until `mem_ready` is seen high.
  - `mem_ready` outside FETCH/MEM_RD/MEM_WR is ignored.
- Instruction retirement happens in the cycle of leaving MEM_WB, MEM_WR (with `mem_ready`), R_WB, I_WB, BRANCH or JUMP. An illegal instruction leaving DECODE does not retire.

## Configuration
- `MC_CTRL_PERF_EN` defined:
  - `cyc_cnt` increments every non-reset cycle.
  - `ins_cnt` increments on each retirement.
  - Both counters clear on reset and wrap modulo 2^PERF_W.
- `MC_CTRL_PERF_EN` undefined: both ports are tied to 0 and no counter flops exist.

## Structure
- Package `mc_pkg` holds:
  - the state enum (4-bit);
  - opcode/funct constants;
  - ALU codes: ADD=5'd0, SUB=5'd1, OR=5'd2, SLT=5'd3, LUI=5'd4;
  - the `reg_dst`, `data_to_reg`, `alu_src_b` and `pc_src` encodings.
- One sub-module, `mc_alu_dec`: maps `op`/`funct`/state class to `alu_ctr` and `ext_op`.

## Test plan
- **addu**: IR=0x00221821, `mem_ready`=1 → FETCH, DECODE, R_EXE, R_WB. `reg_wr`=1 with `reg_dst`=01 in cycle 4 only; `ins_cnt` +1.
- **lw with slow memory**: IR=0x8C230004, `mem_ready` low for 2 cycles in MEM_RD → `mem_rd` and `iord`=1 held for 3 cycles. `reg_wr` and `data_to_reg`=01 follow in MEM_WB. 7 cycles total.
- **beq**: IR=0x10220003 → with `zero`=1, `pc_wr`=1 and `pc_src`=01 in BRANCH. With `zero`=0, `pc_wr`=0. Both cases return to FETCH after 3 cycles.
- **jal**: IR=0x0C000010 → in JUMP, `pc_wr`=1, `pc_src`=10, `reg_wr`=1, `reg_dst`=10, `data_to_reg`=10.
- **Illegal opcode**: IR=0xFC000000 → `illegal` pulses for one cycle in DECODE, next state is FETCH, no `reg_wr`/`mem_wr`, `ins_cnt` unchanged.
- **Reset mid-sw**: `reset`=1 while in MEM_WR → `mem_wr`=0 in that cycle, next state FETCH, counters equal 0.
